// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the synchronous flag FIFO.
package fifo_pkg;

  // Read-mode selectors for the FWFT parameter
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Ceiling log2; returns 0 for values <= 1
  function automatic int fifo_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Pointer/count width: one extra wrap bit above the array address
  function automatic int fifo_ptr_width(input int depth);
    return fifo_clog2(depth) + 1;
  endfunction

  // Legal threshold ranges: almost_full in 1..depth, almost_empty in 0..depth-1
  function automatic bit fifo_thresh_ok(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: ADDR_WIDTH+1 bits, the MSB acting as the wrap bit.
module fifo_ptr #(
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // Advance by one on each enabled cycle, wrapping modulo 2^PTR_W
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with selectable standard/FWFT read, threshold flags,
// exact fill count and one-cycle overflow/underflow pulses.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int FIFO_DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W      = fifo_ptr_width(FIFO_DEPTH);

  localparam logic [PTR_W-1:0] DEPTH_L = PTR_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] AF_L    = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_L    = PTR_W'(AE_THRESH);

  if (!fifo_thresh_ok(FIFO_DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("fifo_sync_flags: AF_THRESH/AE_THRESH outside legal range");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_p1;
  logic                  unf_p1;

  // Requests are accepted against the current flags only; reset masks both
  assign wr_acc = i_we && !fifo_full  && !rst;
  assign rd_acc = i_rd && !fifo_empty && !rst;

  fifo_ptr #(.PTR_W(PTR_W)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .ptr (wptr)
  );

  fifo_ptr #(.PTR_W(PTR_W)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .ptr (rptr)
  );

  // Flags decoded straight from the registered pointers, no extra latency
  assign fill_count   = wptr - rptr;
  assign fifo_empty   = (fill_count == '0);
  assign fifo_full    = (fill_count == DEPTH_L);
  assign almost_full  = (fill_count >= AF_L);
  assign almost_empty = (fill_count <= AE_L);

  // Storage array; contents deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= i_data;
    end
  end

  // Error pulses: one cycle after a rejected request
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_p1 <= 1'b0;
      unf_p1 <= 1'b0;
    end else begin
      ovf_p1 <= i_we && fifo_full;
      unf_p1 <= i_rd && fifo_empty;
    end
  end

  assign overflow  = ovf_p1;
  assign underflow = unf_p1;

  if (FWFT == FIFO_MODE_STD) begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  vld_p1;

    // Registered read port: data and valid land one cycle after the pop
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1     <= 1'b0;
        rd_data_p1 <= '0;
      end else begin
        vld_p1 <= rd_acc;
        if (rd_acc) begin
          rd_data_p1 <= mem[rptr[ADDR_WIDTH-1:0]];
        end
      end
    end

    assign o_data  = rd_data_p1;
    assign o_valid = vld_p1;
  end else begin : g_fwft
    // Head word presented combinationally; i_rd acknowledges it
    assign o_data  = mem[rptr[ADDR_WIDTH-1:0]];
    assign o_valid = !fifo_empty;
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench: standard-mode DUT checked by a read-data scoreboard plus
// inline flag checks, and a second FWFT-mode DUT for fall-through behaviour.
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic       we, rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       vld, full, empty, afull, aempty, ovf, unf;
  logic [3:0] cnt;

  logic       f_we, f_rd;
  logic [7:0] f_din;
  logic [7:0] f_dout;
  logic       f_vld, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [3:0] f_cnt;

  int vectors    = 0;
  int miscompares = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  fifo_sync_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(0),
                    .AF_THRESH(6), .AE_THRESH(1)) dut_std (
    .clk(clk), .rst(rst), .i_we(we), .i_data(din), .i_rd(rd),
    .o_data(dout), .o_valid(vld), .fifo_full(full), .fifo_empty(empty),
    .almost_full(afull), .almost_empty(aempty), .fill_count(cnt),
    .overflow(ovf), .underflow(unf)
  );

  fifo_sync_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1),
                    .AF_THRESH(6), .AE_THRESH(1)) dut_fwft (
    .clk(clk), .rst(rst), .i_we(f_we), .i_data(f_din), .i_rd(f_rd),
    .o_data(f_dout), .o_valid(f_vld), .fifo_full(f_full), .fifo_empty(f_empty),
    .almost_full(f_afull), .almost_empty(f_aempty), .fill_count(f_cnt),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic check(input string name, input int actual, input int required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every valid standard-mode word must match the queue head
  always @(negedge clk) begin
    if (!rst && vld) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read_word", int'(dout), -1);
      end else begin
        check("read_data", int'(dout), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; we = 1'b0; rd = 1'b0; din = '0;
    f_we = 1'b0; f_rd = 1'b0; f_din = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_fill", int'(cnt), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_aempty", int'(aempty), 1);
    check("rst_full", int'(full), 0);
    check("rst_afull", int'(afull), 0);
    check("rst_valid", int'(vld), 0);
    check("rst_data", int'(dout), 0);
    check("rst_pulses", int'({ovf, unf}), 0);
    check("rst_fwft_valid", int'(f_vld), 0);

    // Fill 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; din = 8'h10 + 8'(i);
      step();
      check("fill_count", int'(cnt), i + 1);
      check("fill_afull", int'(afull), (i + 1 >= 6) ? 1 : 0);
    end
    we = 1'b0;
    check("fill_full", int'(full), 1);

    // Overflow while full
    we = 1'b1; din = 8'hAA;
    step();
    we = 1'b0;
    check("ovf_pulse", int'(ovf), 1);
    check("ovf_count", int'(cnt), 8);
    step();
    check("ovf_clear", int'(ovf), 0);

    // Drain 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      rd = 1'b1; exp_q.push_back(8'h10 + 8'(i));
      step();
      check("drain_count", int'(cnt), 7 - i);
      check("drain_aempty", int'(aempty), (7 - i <= 1) ? 1 : 0);
    end
    rd = 1'b0;
    check("drain_empty", int'(empty), 1);
    step();

    // Underflow while empty
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("unf_pulse", int'(unf), 1);
    check("unf_valid", int'(vld), 0);
    step();
    check("unf_clear", int'(unf), 0);

    // Concurrent read/write at count 4 across pointer wrap
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; din = 8'h20 + 8'(i);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      we = 1'b1; rd = 1'b1; din = 8'h24 + 8'(i);
      exp_q.push_back(8'h20 + 8'(i));
      step();
      check("rw_count", int'(cnt), 4);
      check("rw_pulses", int'({ovf, unf}), 0);
    end
    we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd = 1'b1; exp_q.push_back(8'h34 + 8'(i));
      step();
    end
    rd = 1'b0;
    check("rw_empty", int'(empty), 1);
    step();

    // Full with simultaneous read and write: read wins, write rejected
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; din = 8'h40 + 8'(i);
      step();
    end
    we = 1'b1; rd = 1'b1; din = 8'h99;
    exp_q.push_back(8'h40);
    step();
    we = 1'b0; rd = 1'b0;
    check("fullrw_ovf", int'(ovf), 1);
    check("fullrw_unf", int'(unf), 0);
    check("fullrw_count", int'(cnt), 7);
    for (int i = 1; i < 8; i++) begin
      rd = 1'b1; exp_q.push_back(8'h40 + 8'(i));
      step();
    end
    rd = 1'b0;
    check("fullrw_empty", int'(empty), 1);
    step();

    // Reset mid-stream at count 5 with a write pending
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; din = 8'h50 + 8'(i);
      step();
    end
    check("pre_rst_count", int'(cnt), 5);
    rst = 1'b1; we = 1'b1; din = 8'h77;
    step();
    rst = 1'b0; we = 1'b0;
    check("mid_rst_count", int'(cnt), 0);
    check("mid_rst_empty", int'(empty), 1);
    check("mid_rst_aempty", int'(aempty), 1);
    check("mid_rst_valid", int'(vld), 0);
    check("mid_rst_pulses", int'({ovf, unf}), 0);
    we = 1'b1; din = 8'h3C;
    step();
    we = 1'b0; rd = 1'b1; exp_q.push_back(8'h3C);
    step();
    rd = 1'b0;
    check("post_rst_empty", int'(empty), 1);
    step(); step();
    check("scoreboard_drained", exp_q.size(), 0);

    // FWFT: single word falls through without a read
    f_we = 1'b1; f_din = 8'h5C;
    step();
    f_we = 1'b0;
    check("fwft_valid", int'(f_vld), 1);
    check("fwft_data", int'(f_dout), 8'h5C);
    step();
    check("fwft_hold", int'(f_dout), 8'h5C);
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    check("fwft_pop_valid", int'(f_vld), 0);
    check("fwft_pop_empty", int'(f_empty), 1);

    // FWFT: next word appears the cycle after the pop
    f_we = 1'b1; f_din = 8'h61;
    step();
    f_din = 8'h62;
    step();
    f_we = 1'b0;
    check("fwft_head0", int'(f_dout), 8'h61);
    f_rd = 1'b1;
    step();
    check("fwft_head1", int'(f_dout), 8'h62);
    check("fwft_head1_valid", int'(f_vld), 1);
    step();
    f_rd = 1'b0;
    check("fwft_end_empty", int'(f_empty), 1);
    step();
    check("fwft_unf_none", int'(f_unf), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
